// File: rtl/aes_round_seq.sv
// rtl/aes_round_seq.sv - iterative AES-128 sequencer driving one shared external round unit
//
// Optional build macro: AES_RNDTAP_EN (adds tap_valid / tap_data state observation outputs)
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready         plaintext + key handshake (in_data, in_key)
//   out_valid/out_ready       ciphertext handshake (out_data)
//   busy                      a block is in flight (RUN or DONE)
//   rnd_state_o, rnd_key_o    current state / round key presented to the round unit
//   rnd_num_o, rnd_final_o    round index 1..NR and final-round flag (skip MixColumns)
//   rnd_state_i, rnd_key_i    round-unit result state and next round key
//   tap_valid, tap_data       (AES_RNDTAP_EN only) pulse + value at every state update
module aes_round_seq #(
  parameter int NR           = 10,
  parameter int ROUND_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic [127:0] rnd_state_o,
  output logic [127:0] rnd_key_o,
  output logic [3:0]   rnd_num_o,
  output logic         rnd_final_o,
  input  logic [127:0] rnd_state_i,
  input  logic [127:0] rnd_key_i
`ifdef AES_RNDTAP_EN
  ,
  output logic         tap_valid,
  output logic [127:0] tap_data
`endif
);

  // Counter is at least one bit wide so ROUND_CYCLES==1 still elaborates cleanly.
  localparam int CW = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ROUND_CYCLES - 1);
  localparam logic [3:0]    NR_L     = 4'(NR);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e         fsm_q, fsm_d;
  logic [127:0]   state_q, state_d;
  logic [127:0]   key_q, key_d;
  logic [3:0]     rnd_q, rnd_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           out_valid_q, out_valid_d;
  logic           busy_q, busy_d;
  logic           state_upd;
  logic           accept;
  logic           round_done;

  // DONE forwards out_ready so a new block can load on the same edge the
  // result is taken, giving back-to-back throughput.
  assign in_ready   = (fsm_q == S_IDLE) || ((fsm_q == S_DONE) && out_ready);
  assign accept     = in_valid && in_ready;
  assign round_done = (fsm_q == S_RUN) && (cnt_q == CNT_LAST);

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    key_d       = key_q;
    rnd_d       = rnd_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    state_upd   = 1'b0;

    unique case (fsm_q)
      S_IDLE: begin
        if (accept) begin
          fsm_d     = S_RUN;
          state_d   = in_data ^ in_key;
          key_d     = in_key;
          rnd_d     = 4'd1;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_upd = 1'b1;
        end
      end
      S_RUN: begin
        if (round_done) begin
          state_d   = rnd_state_i;
          key_d     = rnd_key_i;
          cnt_d     = '0;
          state_upd = 1'b1;
          if (rnd_q == NR_L) begin
            fsm_d       = S_DONE;
            out_valid_d = 1'b1;
          end else begin
            rnd_d = rnd_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (in_valid) begin
            fsm_d     = S_RUN;
            state_d   = in_data ^ in_key;
            key_d     = in_key;
            rnd_d     = 4'd1;
            cnt_d     = '0;
            state_upd = 1'b1;
          end else begin
            fsm_d  = S_IDLE;
            busy_d = 1'b0;
          end
        end
      end
      default: begin
        fsm_d       = S_IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= S_IDLE;
      state_q     <= '0;
      key_q       <= '0;
      rnd_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      key_q       <= key_d;
      rnd_q       <= rnd_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // state_q only moves at load and round boundaries, so it serves both as
  // the held ciphertext in DONE and as the round-unit operand in RUN.
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign out_data    = state_q;
  assign rnd_state_o = state_q;
  assign rnd_key_o   = key_q;
  assign rnd_num_o   = rnd_q;
  assign rnd_final_o = (rnd_q == NR_L);

`ifdef AES_RNDTAP_EN
  logic         tap_valid_q;
  logic [127:0] tap_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap_valid_q <= 1'b0;
      tap_data_q  <= '0;
    end else begin
      tap_valid_q <= state_upd;
      if (state_upd) begin
        tap_data_q <= state_d;
      end
    end
  end

  assign tap_valid = tap_valid_q;
  assign tap_data  = tap_data_q;
`else
  logic unused_upd;
  assign unused_upd = state_upd;
`endif

endmodule

// File: tb/tb_aes_round_seq.sv
// tb/tb_aes_round_seq.sv - scoreboard bench for aes_round_seq with behavioural AES round model
module tb_aes_round_seq;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_T0  = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] K2     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT2    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT2    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy, a_rf_o;
  logic [127:0] a_in_data, a_in_key, a_out_data, a_rs_o, a_rk_o, a_rs_i, a_rk_i;
  logic [3:0] a_rn_o;
  logic b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy, b_rf_o;
  logic [127:0] b_in_data, b_in_key, b_out_data, b_rs_o, b_rk_o, b_rs_i, b_rk_i;
  logic [3:0] b_rn_o;
`ifdef AES_RNDTAP_EN
  logic a_tap_valid, b_tap_valid;
  logic [127:0] a_tap_data, b_tap_data;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [127:0] a_exp_q[$];
  logic [127:0] b_exp_q[$];
  logic [127:0] a_taps[$];

  // ---------------- behavioural AES round / key-expansion model ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv  = 8'h01;
    logic [7:0] base = x;
    logic [7:0] e    = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[0]) inv = gmul(inv, base);
      base = gmul(base, base);
      e = e >> 1;
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic fin);
    logic [7:0] a[16];
    logic [7:0] b[16];
    logic [7:0] m0, m1, m2, m3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++)
        b[rr+4*c] = a[rr+4*((c+rr)%4)];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        m0 = b[4*c]; m1 = b[4*c+1]; m2 = b[4*c+2]; m3 = b[4*c+3];
        b[4*c]   = gmul(8'h02, m0) ^ gmul(8'h03, m1) ^ m2 ^ m3;
        b[4*c+1] = m0 ^ gmul(8'h02, m1) ^ gmul(8'h03, m2) ^ m3;
        b[4*c+2] = m0 ^ m1 ^ gmul(8'h02, m2) ^ gmul(8'h03, m3);
        b[4*c+3] = gmul(8'h03, m0) ^ m1 ^ m2 ^ gmul(8'h02, m3);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
    return r;
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [3:0] n);
    logic [7:0] rc = 8'h01;
    logic [31:0] t, n0, n1, n2, n3;
    for (int i = 1; i < int'(n); i++) rc = xt(rc);
    t  = {sbox(k[23:16]) ^ rc, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  assign a_rk_i = key_step(a_rk_o, a_rn_o);
  assign a_rs_i = aes_round(a_rs_o, a_rf_o) ^ a_rk_i;
  assign b_rk_i = key_step(b_rk_o, b_rn_o);
  assign b_rs_i = aes_round(b_rs_o, b_rf_o) ^ b_rk_i;

  // ---------------- DUTs ----------------
  aes_round_seq #(.NR(10), .ROUND_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_key(a_in_key),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .busy(a_busy),
    .rnd_state_o(a_rs_o), .rnd_key_o(a_rk_o), .rnd_num_o(a_rn_o), .rnd_final_o(a_rf_o),
    .rnd_state_i(a_rs_i), .rnd_key_i(a_rk_i)
`ifdef AES_RNDTAP_EN
    , .tap_valid(a_tap_valid), .tap_data(a_tap_data)
`endif
  );

  aes_round_seq #(.NR(10), .ROUND_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_key(b_in_key),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .busy(b_busy),
    .rnd_state_o(b_rs_o), .rnd_key_o(b_rk_o), .rnd_num_o(b_rn_o), .rnd_final_o(b_rf_o),
    .rnd_state_i(b_rs_i), .rnd_key_i(b_rk_i)
`ifdef AES_RNDTAP_EN
    , .tap_valid(b_tap_valid), .tap_data(b_tap_data)
`endif
  );

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && a_out_valid && a_out_ready) begin
      if (a_exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL a_unexpected_output: got %h expected none", a_out_data);
      end else begin
        chk("a_out_data", a_out_data, a_exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_out_valid && b_out_ready) begin
      if (b_exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL b_unexpected_output: got %h expected none", b_out_data);
      end else begin
        chk("b_out_data", b_out_data, b_exp_q.pop_front());
      end
    end
  end

`ifdef AES_RNDTAP_EN
  always @(negedge clk) begin
    if (a_tap_valid) a_taps.push_back(a_tap_data);
  end
`endif

  // Presents a block on DUT A (sel=0) or B (sel=1); returns 1ns after the handshake edge.
  task automatic send(input bit sel, input logic [127:0] d, input logic [127:0] k);
    logic rdy = 1'b0;
    if (sel) begin b_in_data = d; b_in_key = k; b_in_valid = 1'b1; end
    else begin a_in_data = d; a_in_key = k; a_in_valid = 1'b1; end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      rdy = sel ? b_in_ready : a_in_ready;
      if (rdy) break;
    end
    chk(sel ? "b_send_ready" : "a_send_ready", 128'(rdy), 128'd1);
    @(posedge clk);
    #1;
    if (sel) b_in_valid = 1'b0; else a_in_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit sel);
    logic bz = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      bz = sel ? b_busy : a_busy;
      if (!bz) break;
    end
    chk(sel ? "b_idle_timeout" : "a_idle_timeout", 128'(bz), 128'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int early, rn_bad, fin_cnt, fin_bad, bp_bad, tap_base;
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_in_key = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_key = '0; b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_data", a_out_data, 128'd0);
    chk("rst_ctrl", 128'({a_out_valid, a_busy, a_rf_o, a_rn_o}), 128'd0);
    chk("rst_rnd_state", a_rs_o, 128'd0);
    chk("rst_rnd_key", a_rk_o, 128'd0);
`ifdef AES_RNDTAP_EN
    chk("rst_tap", 128'(a_tap_valid) | a_tap_data, 128'd0);
`endif
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", 128'(a_in_ready), 128'd1);
    @(posedge clk); #1;

    // C.1 on A: latency and final-round flag
    tap_base = a_taps.size();
    a_exp_q.push_back(C1_CT);
    send(1'b0, C1_PT, C1_KEY);
    early = 0; rn_bad = 0; fin_cnt = 0; fin_bad = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (a_out_valid) early++;
      if (int'(a_rn_o) != j + 1) rn_bad++;
      if (a_rf_o) begin fin_cnt++; if (j != 9) fin_bad++; end
    end
    @(negedge clk);
    chk("c1_latency_valid", 128'(a_out_valid), 128'd1);
    chk("c1_early_valid", 128'(early), 128'd0);
    chk("c1_rnd_sequence", 128'(rn_bad), 128'd0);
    chk("c1_final_count", 128'(fin_cnt), 128'd1);
    chk("c1_final_placement", 128'(fin_bad), 128'd0);
    @(posedge clk); #1;
    wait_idle(1'b0);
`ifdef AES_RNDTAP_EN
    chk("tap_pulses", 128'(a_taps.size() - tap_base), 128'd11);
    if (a_taps.size() > tap_base) begin
      chk("tap_first", a_taps[tap_base], C1_T0);
      chk("tap_last", a_taps[a_taps.size()-1], C1_CT);
    end
`endif

    // ROUND_CYCLES=3 on B
    b_exp_q.push_back(CT2);
    send(1'b1, PT2, K2);
    early = 0; rn_bad = 0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (b_out_valid) early++;
      if (int'(b_rn_o) != j / 3 + 1) rn_bad++;
    end
    @(negedge clk);
    chk("rc3_latency_valid", 128'(b_out_valid), 128'd1);
    chk("rc3_early_valid", 128'(early), 128'd0);
    chk("rc3_rnd_hold", 128'(rn_bad), 128'd0);
    @(posedge clk); #1;
    wait_idle(1'b1);

    // Backpressure then back-to-back load on A
    a_out_ready = 1'b0;
    a_exp_q.push_back(C1_CT);
    send(1'b0, C1_PT, C1_KEY);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (a_out_valid) break;
    end
    chk("bp_done_seen", 128'(a_out_valid), 128'd1);
    bp_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!(a_out_valid && a_out_data == C1_CT && !a_in_ready && a_busy)) bp_bad++;
    end
    chk("bp_stable", 128'(bp_bad), 128'd0);
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    a_in_valid = 1'b1; a_in_data = PT2; a_in_key = K2;
    a_exp_q.push_back(CT2);
    @(negedge clk);
    chk("b2b_in_ready", 128'(a_in_ready), 128'd1);
    @(posedge clk); #1 a_in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_straight_to_run", 128'({a_busy, a_out_valid, a_in_ready}), 128'd4);
    @(posedge clk); #1;
    wait_idle(1'b0);

    // Reset in round 5, then all-zero block
    send(1'b0, C1_PT, C1_KEY);
    repeat (4) @(posedge clk);
    #2;
    chk("mid_run_round5", 128'(a_rn_o), 128'd5);
    rst = 1'b1;
    #1;
    chk("async_rst_ctrl", 128'({a_out_valid, a_busy, a_rf_o, a_rn_o}), 128'd0);
    chk("async_rst_data", a_out_data | a_rs_o | a_rk_o, 128'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    a_exp_q.push_back(Z_CT);
    send(1'b0, 128'd0, 128'd0);
    wait_idle(1'b0);

    chk("a_queue_drained", 128'(a_exp_q.size()), 128'd0);
    chk("b_queue_drained", 128'(b_exp_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
